// File: rtl/pulse_burst_trigger.sv
// rtl/pulse_burst_trigger.sv - edge-triggered delayed pulse burst generator
module pulse_burst_trigger #(
  parameter int CW    = 8,
  parameter int DELAY = 5,
  parameter int HIGH  = 1,
  parameter int LOW   = 1,
  parameter int COUNT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic on,
  input  logic abort,
  output logic signal,
  output logic busy,
  output logic done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_PHIGH = 2'd2;
  localparam logic [1:0] S_PLOW  = 2'd3;

  // Phase counters hold "cycles remaining minus one" so expiry is a zero test.
  localparam logic [CW-1:0] DELAY_M1 = CW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CW-1:0] HIGH_M1  = CW'(HIGH - 1);
  localparam logic [CW-1:0] LOW_M1   = CW'(LOW - 1);
  localparam logic [CW-1:0] COUNT_M1 = CW'(COUNT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pcnt;
  logic          on_q;
  logic          start;

  assign start = on & ~on_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pcnt   <= '0;
      on_q   <= 1'b0;
      signal <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      on_q <= on;
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        state  <= S_IDLE;
        cnt    <= '0;
        pcnt   <= '0;
        signal <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              busy <= 1'b1;
              pcnt <= COUNT_M1;
              if (DELAY == 0) begin
                state  <= S_PHIGH;
                signal <= 1'b1;
                cnt    <= HIGH_M1;
              end else begin
                state <= S_WAIT;
                cnt   <= DELAY_M1;
              end
            end
          end
          S_WAIT: begin
            if (cnt == '0) begin
              state  <= S_PHIGH;
              signal <= 1'b1;
              cnt    <= HIGH_M1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_PHIGH: begin
            if (cnt == '0) begin
              signal <= 1'b0;
              // The last pulse ends the burst without its trailing low phase.
              if (pcnt == '0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_PLOW;
                pcnt  <= pcnt - 1'b1;
                cnt   <= LOW_M1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            if (cnt == '0) begin
              state  <= S_PHIGH;
              signal <= 1'b1;
              cnt    <= HIGH_M1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_trigger.sv
// tb/tb_pulse_burst_trigger.sv - directed self-checking bench for pulse_burst_trigger
module tb_pulse_burst_trigger;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic on_a  = 1'b0;
  logic on_b  = 1'b0;
  logic abort = 1'b0;
  logic sig_a, busy_a, done_a;
  logic sig_b, busy_b, done_b;
  int   n_cmp = 0;
  int   n_err = 0;
  int   dcnt;

  always #5 clock = ~clock;

  pulse_burst_trigger #(.CW(8), .DELAY(3), .HIGH(2), .LOW(1), .COUNT(2)) dut_a (
    .clock(clock), .reset(reset), .on(on_a), .abort(abort),
    .signal(sig_a), .busy(busy_a), .done(done_a)
  );

  pulse_burst_trigger #(.CW(8), .DELAY(0), .HIGH(1), .LOW(1), .COUNT(3)) dut_b (
    .clock(clock), .reset(reset), .on(on_b), .abort(abort),
    .signal(sig_b), .busy(busy_b), .done(done_b)
  );

  // Expected {signal,busy,done} j edges after the accepting edge.
  function automatic logic [2:0] model(int d, int h, int l, int c, int j);
    int total;
    logic s, b, dn;
    total = d + c * h + (c - 1) * l;
    b  = (j >= 0) && (j < total);
    dn = (j == total);
    s  = b && (j >= d) && (((j - d) % (h + l)) < h);
    return {s, b, dn};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_n(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    chk("reset_a", {sig_a, busy_a, done_a}, 3'b000);
    chk("reset_b", {sig_b, busy_b, done_b}, 3'b000);
    reset = 1'b1;
    edge_n(2);

    // 1: plain burst
    on_a = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      edge_n(1);
      chk($sformatf("s1_e%0d", j), {sig_a, busy_a, done_a}, model(3, 2, 1, 2, j));
      if (j == 0) on_a = 1'b0;
    end
    edge_n(2);

    // 2: edges during the burst are ignored
    on_a = 1'b1;
    dcnt = 0;
    for (int j = 0; j <= 10; j++) begin
      edge_n(1);
      chk($sformatf("s2_e%0d", j), {sig_a, busy_a, done_a}, model(3, 2, 1, 2, j));
      dcnt += int'(done_a);
      if (j == 1) on_a = 1'b0;
      if (j == 4) on_a = 1'b1;
    end
    chk("s2_done_count", dcnt, 1);
    on_a = 1'b0;
    edge_n(2);

    // 3: abort in the first high phase, then a fresh burst
    on_a = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      edge_n(1);
      chk($sformatf("s3_e%0d", j), {sig_a, busy_a, done_a},
          (j < 4) ? model(3, 2, 1, 2, j) : 3'b000);
      if (j == 0) on_a = 1'b0;
      if (j == 3) abort = 1'b1;
      if (j == 4) abort = 1'b0;
    end
    on_a = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      edge_n(1);
      chk($sformatf("s3_re%0d", k), {sig_a, busy_a, done_a}, model(3, 2, 1, 2, k));
      if (k == 0) on_a = 1'b0;
    end
    edge_n(2);

    // 4: zero delay, single-cycle pulses
    on_b = 1'b1;
    for (int j = 0; j <= 7; j++) begin
      edge_n(1);
      chk($sformatf("s4_e%0d", j), {sig_b, busy_b, done_b}, model(0, 1, 1, 3, j));
      if (j == 0) on_b = 1'b0;
    end
    edge_n(2);

    // 5: asynchronous reset during a high phase, on held high through release
    on_a = 1'b1;
    edge_n(4);
    chk("s5_pre", {sig_a, busy_a, done_a}, 3'b110);
    #2;
    reset = 1'b0;
    #1;
    chk("s5_async_a", {sig_a, busy_a, done_a}, 3'b000);
    chk("s5_async_b", {sig_b, busy_b, done_b}, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    for (int j = 0; j <= 3; j++) begin
      edge_n(1);
      chk($sformatf("s5_e%0d", j), {sig_a, busy_a, done_a}, model(3, 2, 1, 2, j));
    end
    on_a = 1'b0;
    edge_n(10);

    // 6: start on the done edge is ignored, one edge later is accepted
    on_a = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      edge_n(1);
      chk($sformatf("s6_e%0d", j), {sig_a, busy_a, done_a},
          (j <= 8) ? model(3, 2, 1, 2, j) :
          (j == 9) ? 3'b000 : model(3, 2, 1, 2, j - 10));
      if (j == 6) on_a = 1'b0;
      if (j == 7) on_a = 1'b1;
      if (j == 8) on_a = 1'b0;
      if (j == 9) on_a = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_burst_trigger.md
Name: pulse_burst_trigger

Overview:
- Synthesizable, clock-driven trigger stage. It sits directly downstream of the clock generator and replaces the `#`-delay trigger/pulse behavioural models.
- A rising edge on `on` starts a programmable delay. After the delay, the block emits a burst of COUNT pulses of programmable high and low width.
- It reports `busy` while active and a one-cycle `done` when the burst completes.
- The output feeds waveform-checking benches and downstream event logic.

Parameters:
- CW, 8: width of all internal counters.
- DELAY, 5: cycles from the detected edge to the first signal rise (0 allowed).
- HIGH, 1: cycles signal stays high per pulse (>=1).
- LOW, 1: cycles signal stays low between pulses (>=1).
- COUNT, 2: pulses per burst (>=1).
- Constraint: DELAY, HIGH, LOW and COUNT must each be < 2^CW.

Ports:
- clock, input, 1: single system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- on, input, 1: trigger request. Only its rising edge matters.
- abort, input, 1: synchronous cancel of the current burst.
- signal, output, 1: registered burst output.
- busy, output, 1: registered; high while a burst is in progress.
- done, output, 1: registered; one-cycle pulse when a burst completes normally.

Behaviour:
- Reset (reset=0, asynchronous):
  - signal=0, busy=0, done=0.
  - FSM goes to IDLE; all counters = 0; on_q = 0.
  - Applies immediately, including mid-burst. There is no resume after reset.
- Edge detect:
  - on_q is a register of `on`.
  - start = on & ~on_q, sampled at a clock edge.
  - If `on` is already high at reset release, the first clock edge counts as a rising edge.
- Edge acceptance:
  - start is acted on only when the FSM is in IDLE and abort=0.
  - Edges while busy are ignored, not queued.
- FSM states: IDLE, WAIT, PHIGH, PLOW.
  - IDLE --start, DELAY>0--> WAIT. Delay counter loaded; busy=1 at this edge (edge N).
  - IDLE --start, DELAY=0--> PHIGH. signal=1 at edge N.
  - WAIT --delay count expired--> PHIGH. signal rises at edge N+DELAY.
  - PHIGH --HIGH cycles elapsed, pulses remaining--> PLOW. signal=0.
  - PLOW --LOW cycles elapsed--> PHIGH. signal=1.
  - PHIGH --HIGH cycles elapsed, last pulse--> IDLE.
    - At that edge: signal=0, busy=0, done=1.
    - The trailing LOW phase of the last pulse is not executed.
  - Any non-IDLE state --abort=1--> IDLE. signal=0, busy=0, done stays 0.
- done is high for exactly one cycle. It is cleared at the next edge.
- Back-to-back bursts:
  - A start sampled at the same edge the FSM returns to IDLE is ignored.
  - A start sampled at the next edge is accepted. This gives a minimum of 1 idle cycle between bursts.
- Counters:
  - Unsigned CW-bit; they count down and reload per phase.
  - The pulse counter decrements on each PHIGH exit.
  - No counter wraps in legal configurations.
- Latency: the first signal rise occurs exactly DELAY cycles after the edge at which start is accepted.
- Total burst length: DELAY + COUNT*HIGH + (COUNT-1)*LOW cycles.

Test Plan:
1. DELAY=3, HIGH=2, LOW=1, COUNT=2; `on` rises, start accepted at edge 10 -> busy=1 at edge 10; signal high at edges 13-14 and 16-17 (low elsewhere); at edge 18: signal=0, busy=0, done=1 for 1 cycle.
2. Same config; `on` toggles low/high again at edges 12 and 15 -> ignored; waveform identical to scenario 1; exactly one done.
3. Same config; abort=1 sampled at edge 14 -> signal=0, busy=0 at edge 14; done never asserts; a new `on` edge at edge 20 -> busy at 20, signal rises at 23.
4. DELAY=0, HIGH=1, LOW=1, COUNT=3; start at edge 5 -> signal high at 5, 7, 9 (low at 6, 8); done=1 and busy=0 at edge 10.
5. reset driven low between clock edges during PHIGH of scenario 1 (t between edges 13 and 14) -> signal, busy, done = 0 immediately; after release with `on` held high, a new burst starts at the first edge.
6. `on` held high across completion: start accepted at edge 0 (DELAY=3, HIGH=2, LOW=1, COUNT=2), `on` dropped then raised so start is sampled at edge 8 (done edge) -> ignored; raised again so start is sampled at edge 10 -> accepted, busy=1 at 10.
